// File: rtl/mux_2_1.sv
// ---------------------------------------------------------------------------
// mux_2_1
//
// Parameterised 2:1 selector used to steer either the seed or the shifted /
// feedback bit into an LFSR flip-flop. The combinational result `out` feeds a
// downstream flop directly. An optional registered copy `out_q` is provided
// for places where a pipelined select is wanted.
//
// Parameters:
//   WIDTH      - bit width of in0, in1, out and out_q
//   RESET_VAL  - value loaded into out_q on reset (WIDTH bits)
//
// Ports:
//   clk    in   1      rising-edge clock, used by the registered path only
//   reset  in   1      synchronous active-high reset, clears out_q only
//   in0    in   WIDTH  data chosen when sel = 0
//   in1    in   WIDTH  data chosen when sel = 1
//   sel    in   1      select: 0 -> in0, 1 -> in1
//   en     in   1      load enable for out_q (1 = capture, 0 = hold)
//   out    out  WIDTH  combinational select result
//   out_q  out  WIDTH  registered select result
// ---------------------------------------------------------------------------
module mux_2_1 #(
    parameter int                 WIDTH     = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q
);

    // Single shared select helper so the combinational and registered paths
    // can never disagree about which input is chosen.
    function automatic logic [WIDTH-1:0] select_fn(
        input logic             s,
        input logic [WIDTH-1:0] d0,
        input logic [WIDTH-1:0] d1
    );
        logic [WIDTH-1:0] r;
        r = d0;
        if (s) begin
            r = d1;
        end else begin
            r = d0;
        end
        return r;
    endfunction

    logic [WIDTH-1:0] sel_val_s;
    logic [WIDTH-1:0] out_d;

    // Zero-latency select; deliberately independent of clk, reset and en so
    // that an LFSR stage with sel tied to reset sees the seed during reset.
    always_comb begin
        sel_val_s = select_fn(sel, in0, in1);
    end

    assign out = sel_val_s;

    // Next value of the registered copy: capture when enabled, else hold.
    always_comb begin
        out_d = out_q;
        if (en) begin
            out_d = sel_val_s;
        end else begin
            out_d = out_q;
        end
    end

    // Registered copy with synchronous reset taking priority over en.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= RESET_VAL;
        end else begin
            out_q <= out_d;
        end
    end

endmodule

// File: tb/tb_mux_2_1.sv
// ---------------------------------------------------------------------------
// tb_mux_2_1 - directed self-checking bench for mux_2_1.
// Three instances: a WIDTH=1 cell for the truth table, a WIDTH=8 cell for the
// registered path, and a WIDTH=1 cell wired LFSR-style with sel tied to reset.
// ---------------------------------------------------------------------------
module tb_mux_2_1;

    logic clk;
    int   n_checks;
    int   n_errors;

    // WIDTH=1 instance
    logic       r1, a1, b1, s1, e1, o1, q1;
    // WIDTH=8 instance
    logic       r8, s8, e8;
    logic [7:0] a8, b8, o8, q8;
    // LFSR-style instance
    logic       rl, ol, ql;

    mux_2_1 #(.WIDTH(1), .RESET_VAL(1'b0)) u_w1 (
        .clk(clk), .reset(r1), .in0(a1), .in1(b1), .sel(s1), .en(e1),
        .out(o1), .out_q(q1)
    );

    mux_2_1 #(.WIDTH(8), .RESET_VAL(8'h00)) u_w8 (
        .clk(clk), .reset(r8), .in0(a8), .in1(b8), .sel(s8), .en(e8),
        .out(o8), .out_q(q8)
    );

    mux_2_1 #(.WIDTH(1), .RESET_VAL(1'b0)) u_lfsr (
        .clk(clk), .reset(rl), .in0(1'b0), .in1(1'b1), .sel(rl), .en(1'b1),
        .out(ol), .out_q(ql)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic       vs [3];
        logic [7:0] exp8;
        logic       exp1;

        n_checks = 0;
        n_errors = 0;
        r1 = 1'b1; a1 = 1'b0; b1 = 1'b0; s1 = 1'b0; e1 = 1'b1;
        r8 = 1'b1; a8 = 8'h00; b8 = 8'h00; s8 = 1'b0; e8 = 1'b1;
        rl = 1'b1;

        tick();
        tick();
        // Reset state
        check_eq("rst_q8", {24'h0, q8}, 32'h00);
        check_eq("rst_q1", {31'h0, q1}, 32'h0);
        check_eq("lfsr_out_in_reset", {31'h0, ol}, 32'h1);
        check_eq("lfsr_q_in_reset", {31'h0, ql}, 32'h0);

        // Test 5: release LFSR reset, out must switch to in0 (0)
        rl = 1'b0;
        #1;
        check_eq("lfsr_out_after_rst", {31'h0, ol}, 32'h0);
        tick();
        check_eq("lfsr_out_next_cyc", {31'h0, ol}, 32'h0);

        // Test 1: truth table, {in0,in1,sel} = i
        r1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a1 = i[2];
            b1 = i[1];
            s1 = i[0];
            exp1 = i[0] ? i[1] : i[2];
            #1;
            check_eq($sformatf("tt_%0d", i), {31'h0, o1}, {31'h0, exp1});
        end
        // registered copy of last vector (in0=1,in1=1,sel=1 -> 1)
        tick();
        check_eq("tt_q", {31'h0, q1}, 32'h1);

        // Test 2: toggle sel with en=1
        r8 = 1'b0; e8 = 1'b1; a8 = 8'hA5; b8 = 8'h3C; s8 = 1'b0;
        #1;
        check_eq("t2_out_a5", {24'h0, o8}, 32'hA5);
        tick();
        check_eq("t2_q_a5", {24'h0, q8}, 32'hA5);
        s8 = 1'b1;
        #1;
        check_eq("t2_out_3c", {24'h0, o8}, 32'h3C);
        check_eq("t2_q_lat", {24'h0, q8}, 32'hA5);
        tick();
        check_eq("t2_q_3c", {24'h0, q8}, 32'h3C);
        s8 = 1'b0;
        #1;
        check_eq("t2_out_a5b", {24'h0, o8}, 32'hA5);
        tick();
        check_eq("t2_q_a5b", {24'h0, q8}, 32'hA5);

        // Test 3: reset with en=1, sel=1, in1=FF
        r8 = 1'b1; s8 = 1'b1; b8 = 8'hFF;
        #1;
        check_eq("t3_out_pre", {24'h0, o8}, 32'hFF);
        tick();
        check_eq("t3_q_rst", {24'h0, q8}, 32'h00);
        check_eq("t3_out_post", {24'h0, o8}, 32'hFF);
        r8 = 1'b0;

        // Load 3C then hold with en=0
        b8 = 8'h3C;
        tick();
        check_eq("t4_load", {24'h0, q8}, 32'h3C);

        va[0] = 8'h11; vb[0] = 8'h22; vs[0] = 1'b0;
        va[1] = 8'h33; vb[1] = 8'h44; vs[1] = 1'b1;
        va[2] = 8'hF0; vb[2] = 8'h0F; vs[2] = 1'b0;
        e8 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a8 = va[k];
            b8 = vb[k];
            s8 = vs[k];
            exp8 = vs[k] ? vb[k] : va[k];
            #1;
            check_eq($sformatf("t4_out_%0d", k), {24'h0, o8}, {24'h0, exp8});
            tick();
            check_eq($sformatf("t4_hold_%0d", k), {24'h0, q8}, 32'h3C);
        end

        // Test 6: reset asserted between edges
        e8 = 1'b1; s8 = 1'b0; a8 = 8'h5A;
        tick();
        check_eq("t6_load", {24'h0, q8}, 32'h5A);
        #2;
        r8 = 1'b1;
        #1;
        check_eq("t6_mid", {24'h0, q8}, 32'h5A);
        @(negedge clk);
        check_eq("t6_neg", {24'h0, q8}, 32'h5A);
        tick();
        check_eq("t6_rst", {24'h0, q8}, 32'h00);
        r8 = 1'b0;
        tick();
        check_eq("t6_reload", {24'h0, q8}, 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
